// File: rtl/core_inst_seq_if.sv
// Host-side bundle for the tile instruction sequencer.
// The host drives start, the tile descriptor and ofifo_valid; the sequencer returns inst, busy and done.
interface core_inst_seq_if #(
   parameter int ADDR_W = 11
);
   logic              start;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] a_base;
   logic [ADDR_W-1:0] p_base;
   logic [ADDR_W-1:0] n_act;
   logic              acc_en;
   logic              ofifo_valid;
   logic [33:0]       inst;
   logic              busy;
   logic              done;

   modport master (
      output start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
      input  inst, busy, done
   );

   modport slave (
      input  start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
      output inst, busy, done
   );
endinterface

// File: rtl/core_inst_seq.sv
// Tile instruction sequencer: weight load, activation execute with optional
// psum accumulate, write-back, then OFIFO drain, emitted as a registered 34-bit bundle.
module core_inst_seq #(
   parameter int ROW     = 8,
   parameter int ADDR_W  = 11,
   parameter int MAC_LAT = 8
) (
   input logic             clk,
   input logic             reset,
   core_inst_seq_if.slave  bus
);
   localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
   localparam int CW = ADDR_W + 2 + $clog2(MAC_LAT + 3);

   localparam int B_LOAD  = 0;
   localparam int B_EXEC  = 1;
   localparam int B_L0WR  = 2;
   localparam int B_IFWR  = 5;
   localparam int B_OFRD  = 6;
   localparam int B_WENX  = 18;
   localparam int B_CENX  = 19;
   localparam int B_WENP  = 31;
   localparam int B_CENP  = 32;
   localparam int B_ACC   = 33;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLOAD,
      S_EXEC,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] w_base_q, w_base_d;
   logic [ADDR_W-1:0] a_base_q, a_base_d;
   logic [ADDR_W-1:0] p_base_q, p_base_d;
   logic [ADDR_W-1:0] n_act_q, n_act_d;
   logic              acc_q, acc_d;
   logic [33:0]       inst_q, inst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [CW-1:0]     last_t;
   logic [CW-1:0]     c_end;
   logic [ADDR_W:0]   sl_x, sl_f, sl_e, sl_r, sl_w;

   // {hit, t}: does cycle c carry the event at offset off for some vector t < n
   function automatic logic [ADDR_W:0] slot(
      input logic [CW-1:0]     c,
      input logic [CW-1:0]     off,
      input logic              ii2,
      input logic [ADDR_W-1:0] n
   );
      logic [CW-1:0] d;
      logic [CW-1:0] idx;
      logic          hit;
      d   = c - off;
      idx = ii2 ? (d >> 1) : d;
      hit = (c >= off) && !(ii2 && d[0]) && (idx < CW'(n));
      return {hit, idx[ADDR_W-1:0]};
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_cnt_d = rd_cnt_q;
      w_base_d = w_base_q;
      a_base_d = a_base_q;
      p_base_d = p_base_q;
      n_act_d  = n_act_q;
      acc_d    = acc_q;
      inst_d   = IDLE_INST;
      last_t   = CW'(n_act_q) - CW'(1);
      c_end    = (acc_q ? (last_t << 1) : last_t) + CW'(MAC_LAT + 2);

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_WLOAD;
               cnt_d    = '0;
               rd_cnt_d = '0;
               w_base_d = bus.w_base;
               a_base_d = bus.a_base;
               p_base_d = bus.p_base;
               n_act_d  = bus.n_act;
               acc_d    = bus.acc_en;
            end
         end
         S_WLOAD: begin
            if (cnt_q == CW'(ROW)) begin
               cnt_d   = '0;
               state_d = (n_act_q == '0) ? S_DONE : S_EXEC;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_EXEC: begin
            if (cnt_q == c_end) begin
               state_d  = S_DRAIN;
               cnt_d    = '0;
               rd_cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (rd_cnt_q == n_act_q) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_WLOAD) || (state_d == S_EXEC) ||
               (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);

      sl_x = slot(cnt_d, CW'(0), acc_d, n_act_d);
      sl_f = slot(cnt_d, CW'(1), acc_d, n_act_d);
      sl_e = slot(cnt_d, CW'(2), acc_d, n_act_d);
      sl_r = slot(cnt_d, CW'(MAC_LAT + 1), acc_d, n_act_d);
      sl_w = slot(cnt_d, CW'(MAC_LAT + 2), acc_d, n_act_d);

      // Bundle describes the cycle that begins at the coming edge
      unique case (state_d)
         S_WLOAD: begin
            if (cnt_d < CW'(ROW)) begin
               inst_d[B_CENX] = 1'b0;
               inst_d[17:7]   = w_base_d + cnt_d[ADDR_W-1:0];
            end
            if (cnt_d != '0) begin
               inst_d[B_LOAD] = 1'b1;
               inst_d[B_L0WR] = 1'b1;
            end
         end
         S_EXEC: begin
            if (sl_x[ADDR_W]) begin
               inst_d[B_CENX] = 1'b0;
               inst_d[17:7]   = a_base_d + sl_x[ADDR_W-1:0];
            end
            if (sl_f[ADDR_W]) inst_d[B_IFWR] = 1'b1;
            if (sl_e[ADDR_W]) inst_d[B_EXEC] = 1'b1;
            if (acc_d && sl_r[ADDR_W]) begin
               inst_d[B_CENP] = 1'b0;
               inst_d[30:20]  = p_base_d + sl_r[ADDR_W-1:0];
            end
            if (sl_w[ADDR_W]) begin
               inst_d[B_CENP] = 1'b0;
               inst_d[B_WENP] = 1'b0;
               inst_d[30:20]  = p_base_d + sl_w[ADDR_W-1:0];
               inst_d[B_ACC]  = acc_d;
            end
         end
         S_DRAIN: begin
            inst_d[B_OFRD] = bus.ofifo_valid;
            rd_cnt_d       = rd_cnt_d + ADDR_W'(bus.ofifo_valid);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rd_cnt_q <= '0;
         w_base_q <= '0;
         a_base_q <= '0;
         p_base_q <= '0;
         n_act_q  <= '0;
         acc_q    <= 1'b0;
         inst_q   <= IDLE_INST;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_cnt_q <= rd_cnt_d;
         w_base_q <= w_base_d;
         a_base_q <= a_base_d;
         p_base_q <= p_base_d;
         n_act_q  <= n_act_d;
         acc_q    <= acc_d;
         inst_q   <= inst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.inst = inst_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

   // B_WENX is a constant 1 from IDLE_INST; named for readers of the bit map
   localparam int UNUSED_WENX = B_WENX;
endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: an event-placement schedule model
// compared every cycle, plus literal checks on logged addresses and pulse timing.
module tb_core_inst_seq;
   localparam int ROW = 8;
   localparam int AW  = 11;
   localparam int ML  = 8;
   localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

   logic clk = 1'b0;
   logic reset;

   core_inst_seq_if #(.ADDR_W(AW)) bus ();

   core_inst_seq #(
      .ROW(ROW), .ADDR_W(AW), .MAC_LAT(ML)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [33:0] exp_inst = IDLE_INST;
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   bit          chk_en = 1'b0;

   logic [33:0] sch [0:511];
   int          sch_len;

   int          cyc = 0;
   logic [AW-1:0] xa_log[$];
   logic [AW-1:0] pw_log[$];
   logic [AW-1:0] pr_log[$];
   int          pw_cyc[$];
   int          pr_cyc[$];
   int          ex_cyc[$];
   int          n_l0, n_rd, acc_ones, acc_zeros;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Per-cycle compare against the model and activity logging
   always @(negedge clk) begin
      if (chk_en) begin
         cyc++;
         chk("inst", 64'(bus.inst), 64'(exp_inst));
         chk("busy", 64'(bus.busy), 64'(exp_busy));
         chk("done", 64'(bus.done), 64'(exp_done));
         if (!bus.inst[19]) xa_log.push_back(bus.inst[17:7]);
         if (bus.inst[2]) n_l0++;
         if (bus.inst[1]) ex_cyc.push_back(cyc);
         if (bus.inst[6]) n_rd++;
         if (!bus.inst[32] && !bus.inst[31]) begin
            pw_log.push_back(bus.inst[30:20]);
            pw_cyc.push_back(cyc);
            if (bus.inst[33]) acc_ones++;
            else acc_zeros++;
         end
         if (!bus.inst[32] && bus.inst[31]) begin
            pr_log.push_back(bus.inst[30:20]);
            pr_cyc.push_back(cyc);
         end
      end
   end

   task automatic clear_logs();
      xa_log.delete(); pw_log.delete(); pr_log.delete();
      pw_cyc.delete(); pr_cyc.delete(); ex_cyc.delete();
      n_l0 = 0; n_rd = 0; acc_ones = 0; acc_zeros = 0;
   endtask

   // Model: lay out each event at its slot in a per-cycle table
   task automatic build(input logic [AW-1:0] w, a, p, n, input bit acc);
      int ii;
      int base;
      int s;
      ii = acc ? 2 : 1;
      sch_len = 0;
      for (int k = 0; k <= ROW; k++) begin
         sch[sch_len] = IDLE_INST;
         if (k < ROW) begin
            sch[sch_len][19]   = 1'b0;
            sch[sch_len][17:7] = w + AW'(k);
         end
         if (k >= 1) begin
            sch[sch_len][0] = 1'b1;
            sch[sch_len][2] = 1'b1;
         end
         sch_len++;
      end
      if (n != 0) begin
         base = sch_len;
         for (int i = 0; i < (int'(n) - 1) * ii + ML + 3; i++) begin
            sch[sch_len] = IDLE_INST;
            sch_len++;
         end
         for (int t = 0; t < int'(n); t++) begin
            s = base + t * ii;
            sch[s][19]   = 1'b0;
            sch[s][17:7] = a + AW'(t);
            sch[s + 1][5] = 1'b1;
            sch[s + 2][1] = 1'b1;
            if (acc) begin
               sch[s + 1 + ML][32]    = 1'b0;
               sch[s + 1 + ML][30:20] = p + AW'(t);
            end
            sch[s + 2 + ML][32]    = 1'b0;
            sch[s + 2 + ML][31]    = 1'b0;
            sch[s + 2 + ML][30:20] = p + AW'(t);
            sch[s + 2 + ML][33]    = acc;
         end
      end
   endtask

   task automatic expect_cycle(input logic [33:0] ei, input logic eb,
                               input logic ed);
      exp_inst = ei;
      exp_busy = eb;
      exp_done = ed;
   endtask

   // abort_at < 0 runs the whole tile; otherwise reset hits at that cycle
   task automatic run_tile(input logic [AW-1:0] w, a, p, n, input bit acc,
                           input logic [31:0] vpat, input bit hold,
                           input int abort_at);
      int vi;
      int reads;
      int budget;
      logic sv;
      logic [33:0] word;
      vi = 0;
      build(w, a, p, n, acc);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.w_base = w; bus.a_base = a; bus.p_base = p;
      bus.n_act = n; bus.acc_en = acc;
      clear_logs();
      for (int i = 0; i < sch_len; i++) begin
         @(posedge clk); #1;
         expect_cycle(sch[i], 1'b1, 1'b0);
         if (!hold) bus.start = 1'b0;
         else begin
            bus.w_base = 11'h555; bus.a_base = 11'h2AA;
            bus.n_act = 11'd1; bus.acc_en = ~acc;
         end
         bus.ofifo_valid = vpat[vi % 32];
         vi++;
         if (i == abort_at) begin
            #2;
            reset = 1'b1;
            expect_cycle(IDLE_INST, 1'b0, 1'b0);
            #1;
            chk("abort_inst", 64'(bus.inst), 64'(IDLE_INST));
            chk("abort_busy", 64'(bus.busy), 64'd0);
            bus.start = 1'b0;
            bus.ofifo_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            return;
         end
      end
      reads = 0;
      budget = 0;
      while (reads < int'(n)) begin
         @(posedge clk); #1;
         sv = bus.ofifo_valid;
         word = IDLE_INST;
         word[6] = sv;
         expect_cycle(word, 1'b1, 1'b0);
         reads += int'(sv);
         bus.ofifo_valid = vpat[vi % 32];
         vi++;
         budget++;
         if (budget > 200) begin
            chk("drain_timeout", 64'(reads), 64'(n));
            break;
         end
      end
      @(posedge clk); #1;
      expect_cycle(IDLE_INST, 1'b0, 1'b1);
      bus.start = 1'b0;
      bus.ofifo_valid = 1'b0;
      @(posedge clk); #1;
      expect_cycle(IDLE_INST, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b1;
      bus.w_base = '0; bus.a_base = '0; bus.p_base = '0;
      bus.n_act = 11'd2; bus.acc_en = 1'b0;
      bus.ofifo_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_inst", 64'(bus.inst), 64'h1_800C_0000);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      reset = 1'b0;
      bus.start = 1'b0;
      bus.ofifo_valid = 1'b0;
      repeat (2) @(posedge clk);

      // Weight load and non-accumulating execute
      run_tile(11'h010, 11'h020, 11'h040, 11'd4, 1'b0, '1, 1'b0, -1);
      chk("wl_first_addr", 64'(xa_log[0]), 64'h010);
      chk("wl_last_addr", 64'(xa_log[7]), 64'h017);
      chk("act_first_addr", 64'(xa_log[8]), 64'h020);
      chk("l0_wr_count", 64'(n_l0), 64'd8);
      chk("exec_count", 64'(ex_cyc.size()), 64'd4);
      chk("exec_span", 64'(ex_cyc[3] - ex_cyc[0]), 64'd3);
      chk("pw_count", 64'(pw_log.size()), 64'd4);
      chk("pw_last", 64'(pw_log[3]), 64'h043);
      chk("pw_span", 64'(pw_cyc[3] - pw_cyc[0]), 64'd3);
      chk("no_pread", 64'(pr_log.size()), 64'd0);
      chk("acc0", 64'(acc_ones), 64'd0);

      // Accumulate: reads one cycle ahead of each write
      run_tile(11'h000, 11'h030, 11'h100, 11'd3, 1'b1, '1, 1'b0, -1);
      chk("acc_exec_gap", 64'(ex_cyc[1] - ex_cyc[0]), 64'd2);
      chk("acc_pr_count", 64'(pr_log.size()), 64'd3);
      chk("acc_pr_last", 64'(pr_log[2]), 64'h102);
      for (int t = 0; t < 3; t++)
         chk("acc_rd_wr_gap", 64'(pw_cyc[t] - pr_cyc[t]), 64'd1);
      chk("acc1", 64'(acc_ones), 64'd3);

      // Address wrap, toggling ofifo_valid, start held while busy
      run_tile(11'h000, 11'h7FE, 11'h7FF, 11'd3, 1'b0,
               32'b0110_0101_0011_0110_1001_0100_1100_1010, 1'b1, -1);
      chk("wrap_a0", 64'(xa_log[8]), 64'h7FE);
      chk("wrap_a1", 64'(xa_log[9]), 64'h7FF);
      chk("wrap_a2", 64'(xa_log[10]), 64'h000);
      chk("wrap_p1", 64'(pw_log[1]), 64'h000);
      chk("drain_reads", 64'(n_rd), 64'd3);

      // Empty tile: WLOAD straight to DONE
      run_tile(11'h123, 11'h000, 11'h000, 11'd0, 1'b1, '1, 1'b0, -1);
      chk("empty_exec", 64'(ex_cyc.size()), 64'd0);
      chk("empty_rd", 64'(n_rd), 64'd0);

      // Reset in the middle of EXEC, then a clean tile
      run_tile(11'h005, 11'h006, 11'h007, 11'd5, 1'b1, '1, 1'b0, ROW + 4);
      run_tile(11'h7FC, 11'h200, 11'h300, 11'd2, 1'b1, 32'hAAAA_AAAA,
               1'b0, -1);
      chk("restart_w_wrap", 64'(xa_log[4]), 64'h000);
      chk("restart_pw", 64'(pw_log[1]), 64'h301);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
